// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle fetch/decode/execute/write-back controller and 4x8 register file for the 8-bit CPU.
// Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB), plus one cycle per imem_valid wait.
// Backpressure: stalls in FETCH with imem_req held until imem_valid; HLT parks the core until reset.
module cpu_ctrl_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [7:0]  alu_res,
    input  logic        alu_carry,
    output logic [7:0]  pc,
    output logic        carry_flag,
    output logic        halted,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        carry_q, carry_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  res_q, res_d;
    logic        cyh_q, cyh_d;
    logic        req_q, halted_q;
    logic [7:0]  regs_q [4];
    logic        rf_we;
    logic [7:0]  rf_wdata;

    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  imm;
    logic        is_alu_op;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:10];
    assign rs        = ir_q[9:8];
    assign imm       = ir_q[7:0];
    assign is_alu_op = (op >= 4'h1) && (op <= 4'hA);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        res_d    = res_q;
        cyh_d    = cyh_q;
        rf_we    = 1'b0;
        rf_wdata = 8'h00;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // HLT leaves the ALU operands untouched; they only move on DECODE->EXEC
                if (op == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    a_d     = regs_q[rd];
                    b_d     = regs_q[rs];
                    ctrl_d  = (is_alu_op || op == OP_BEQ) ? op : 4'h0;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                cyh_d   = alu_carry;
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 8'd1;
                if (is_alu_op) begin
                    rf_we    = 1'b1;
                    rf_wdata = res_q;
                    carry_d  = cyh_q;
                end else if (op == OP_LDI) begin
                    rf_we    = 1'b1;
                    rf_wdata = imm;
                end else if (op == OP_JMP) begin
                    pc_d = imm;
                end else if (op == OP_BEQ && !cyh_q) begin
                    pc_d = imm;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            carry_q  <= 1'b0;
            ir_q     <= 16'h0000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            ctrl_q   <= 4'h0;
            res_q    <= 8'h00;
            cyh_q    <= 1'b0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            carry_q  <= carry_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            res_q    <= res_d;
            cyh_q    <= cyh_d;
            req_q    <= (state_d == S_FETCH);
            halted_q <= (state_d == S_HALT);
            if (rf_we) regs_q[rd] <= rf_wdata;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign carry_flag = carry_q;
    assign halted     = halted_q;
    assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Table-driven bench for cpu_ctrl_unit: one instruction per vector, expectations queued at issue
// and compared when the core returns to FETCH; hand-written sequences cover HLT and reset mid-WB.
module tb_cpu_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic [7:0]  pc;
    logic        carry_flag;
    logic        halted;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_ctrl_unit #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_carry(alu_carry),
        .pc(pc), .carry_flag(carry_flag), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Reference combinational ALU
    logic [8:0]  alu_t;
    logic [15:0] alu_p;
    always_comb begin
        alu_t     = 9'h000;
        alu_p     = alu_a * alu_b;
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        case (alu_ctrl)
            4'h1: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_res = alu_t[7:0]; alu_carry = alu_t[8]; end
            4'h2: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_res = alu_t[7:0]; alu_carry = alu_t[8]; end
            4'h3: begin alu_res = alu_p[7:0]; alu_carry = |alu_p[15:8]; end
            4'h4: begin alu_res = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b; alu_carry = (alu_b == 8'h00); end
            4'h5: alu_res = alu_a & alu_b;
            4'h6: alu_res = alu_a | alu_b;
            4'h7: alu_res = alu_a ^ alu_b;
            4'h8: alu_res = ~alu_a;
            4'h9: begin alu_t = {1'b0, alu_a} + 9'd1; alu_res = alu_t[7:0]; alu_carry = alu_t[8]; end
            4'hA: begin alu_t = {1'b0, alu_a} - 9'd1; alu_res = alu_t[7:0]; alu_carry = alu_t[8]; end
            4'hF: alu_carry = (alu_a != alu_b);
            default: alu_res = 8'h00;
        endcase
    end

    typedef struct packed {
        logic [15:0] ins;
        logic [3:0]  stall;
        logic [3:0]  ctrl;   // alu_ctrl expected during EXEC
        logic [1:0]  sel;    // register to read back
        logic [7:0]  val;
        logic        cy;
        logic [7:0]  npc;    // next fetch address
    } vec_t;

    vec_t vecs [19];
    vec_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fetch(output int n);
        n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        int   w;
        vec_t e;
        exp_q.push_back(v);
        n = 0;
        imem_valid = 1'b0;
        imem_rdata = 16'(($urandom));
        for (int s = 0; s < int'(v.stall); s++) begin
            @(negedge clk);
            n++;
        end
        if (v.stall != 4'd0) chk($sformatf("stall_req[%0d]", idx), {31'd0, imem_req}, 32'd1);
        imem_valid = 1'b1;
        imem_rdata = v.ins;
        @(negedge clk);
        n++;
        // Garbage outside FETCH must be ignored
        imem_valid = 1'($urandom);
        imem_rdata = 16'($urandom);
        @(negedge clk);
        n++;
        chk($sformatf("exec_ctrl[%0d]", idx), {28'd0, alu_ctrl}, {28'd0, v.ctrl});
        wait_fetch(w);
        n += w;
        e = exp_q.pop_front();
        dbg_sel = e.sel;
        #1;
        chk($sformatf("latency[%0d]", idx), n, 32'(4 + int'(e.stall)));
        chk($sformatf("addr[%0d]", idx), {24'd0, imem_addr}, {24'd0, e.npc});
        chk($sformatf("reg[%0d]", idx), {24'd0, dbg_data}, {24'd0, e.val});
        chk($sformatf("carry[%0d]", idx), {31'd0, carry_flag}, {31'd0, e.cy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        //           ins       stall ctrl sel  val    cy    npc
        vecs[0]  = '{16'hB4F0, 4'd0, 4'h0, 2'd1, 8'hF0, 1'b0, 8'h01}; // LDI R1,F0
        vecs[1]  = '{16'hB820, 4'd0, 4'h0, 2'd2, 8'h20, 1'b0, 8'h02}; // LDI R2,20
        vecs[2]  = '{16'h1600, 4'd0, 4'h1, 2'd1, 8'h10, 1'b1, 8'h03}; // ADD R1,R2
        vecs[3]  = '{16'hB005, 4'd0, 4'h0, 2'd0, 8'h05, 1'b1, 8'h04}; // LDI R0,05
        vecs[4]  = '{16'hBC05, 4'd0, 4'h0, 2'd3, 8'h05, 1'b1, 8'h05}; // LDI R3,05
        vecs[5]  = '{16'hF340, 4'd0, 4'hF, 2'd3, 8'h05, 1'b1, 8'h40}; // BEQ taken
        vecs[6]  = '{16'hBC06, 4'd0, 4'h0, 2'd3, 8'h06, 1'b1, 8'h41}; // LDI R3,06
        vecs[7]  = '{16'h5500, 4'd0, 4'h5, 2'd1, 8'h10, 1'b0, 8'h42}; // AND R1,R1
        vecs[8]  = '{16'hF380, 4'd0, 4'hF, 2'd0, 8'h05, 1'b0, 8'h43}; // BEQ not taken
        vecs[9]  = '{16'h2C00, 4'd5, 4'h2, 2'd3, 8'h01, 1'b0, 8'h44}; // SUB R3,R0 with stall
        vecs[10] = '{16'hB800, 4'd0, 4'h0, 2'd2, 8'h00, 1'b0, 8'h45}; // LDI R2,00
        vecs[11] = '{16'hA800, 4'd0, 4'hA, 2'd2, 8'hFF, 1'b1, 8'h46}; // DEC R2 borrow
        vecs[12] = '{16'hC0FF, 4'd0, 4'h0, 2'd2, 8'hFF, 1'b1, 8'hFF}; // JMP FF
        vecs[13] = '{16'hD000, 4'd0, 4'h0, 2'd2, 8'hFF, 1'b1, 8'h00}; // NOP wraps pc
        vecs[14] = '{16'h9800, 4'd0, 4'h9, 2'd2, 8'h00, 1'b1, 8'h01}; // INC R2 carry
        vecs[15] = '{16'h3700, 4'd0, 4'h3, 2'd1, 8'h10, 1'b0, 8'h02}; // MUL R1,R3
        vecs[16] = '{16'h7300, 4'd0, 4'h7, 2'd0, 8'h04, 1'b0, 8'h03}; // XOR R0,R3
        vecs[17] = '{16'hE000, 4'd1, 4'h0, 2'd0, 8'h04, 1'b0, 8'h04}; // NOP
        vecs[18] = '{16'hC007, 4'd0, 4'h0, 2'd1, 8'h10, 1'b0, 8'h07}; // JMP 07

        rst_n      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 16'hB4AA;
        dbg_sel    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_alu", {12'd0, alu_a, alu_b, alu_ctrl}, 32'd0);
        chk("rst_flags", {30'd0, carry_flag, halted}, 32'd0);
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            if (dbg_data !== 8'h00) bad++;
        end
        chk("rst_regs", bad, 32'd0);

        imem_valid = 1'b0;
        rst_n = 1'b1;
        wait_fetch(n);
        chk("first_req_delay", n, 32'd1);
        chk("first_addr", {24'd0, imem_addr}, 32'd0);

        for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

        // HLT at 0x07
        imem_valid = 1'b1;
        imem_rdata = 16'h0000;
        @(negedge clk);
        chk("hlt_decode_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_pc", {24'd0, pc}, 32'h07);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            imem_valid = 1'b1;
            imem_rdata = 16'hB4FF;
            @(negedge clk);
            if (imem_req !== 1'b0 || pc !== 8'h07 || halted !== 1'b1) bad++;
        end
        chk("hlt_hold", bad, 32'd0);

        // Reset out of HALT, then reset during WB of an ADD
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(n);
        chk("rehalt_fetch", {24'd0, imem_addr}, 32'd0);
        run_vec('{16'hB433, 4'd0, 4'h0, 2'd1, 8'h33, 1'b0, 8'h01}, 100);
        imem_valid = 1'b1;
        imem_rdata = 16'h1500;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        dbg_sel = 2'd1;
        #1;
        chk("wbrst_reg", {24'd0, dbg_data}, 32'd0);
        chk("wbrst_pc", {24'd0, pc}, 32'd0);
        chk("wbrst_req", {31'd0, imem_req}, 32'd0);
        chk("wbrst_carry", {31'd0, carry_flag}, 32'd0);
        chk("wbrst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("wbrst_refetch", {23'd0, imem_req, imem_addr}, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
